// File: rtl/score_bcd_accum.sv
// Multi-digit BCD score accumulator: edge-detected scoring events are added
// digit-serially, clamped at all-9s, and tracked against a high score.
module score_bcd_accum #(
  parameter int DIGITS = 4,
  parameter int PTR_W  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                score_toggle,
  input  logic [3:0]          add_amount,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] high_score,
  output logic                busy,
  output logic                new_high,
  output logic                saturated,
  output logic                overrun
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, CHECK} state_t;

  state_t           state;
  logic             toggle_q;
  logic             pending;
  logic [3:0]       pend_amt;
  logic [3:0]       amt;
  logic             carry;
  logic [PTR_W-1:0] idx;
  logic [W-1:0]     work;

  logic             event_hit;
  logic [3:0]       amt_clamped;
  logic [3:0]       cur_digit;
  logic [4:0]       digit_sum;
  logic [3:0]       digit_next;
  logic [W-1:0]     digit_mask;
  logic [W-1:0]     work_next;
  logic [W-1:0]     commit_value;

  assign event_hit   = score_toggle & ~toggle_q;
  assign amt_clamped = (add_amount > 4'd9) ? 4'd9 : add_amount;
  assign busy        = (state != IDLE);

  // One BCD digit of the running sum; the amount only enters at the ones digit.
  always_comb begin
    cur_digit    = 4'(work >> {idx, 2'b00});
    digit_sum    = {1'b0, cur_digit} + {1'b0, (idx == '0) ? amt : 4'd0} + {4'b0, carry};
    digit_next   = (digit_sum > 5'd9) ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
    digit_mask   = W'(4'hF) << {idx, 2'b00};
    work_next    = (work & ~digit_mask) | (W'(digit_next) << {idx, 2'b00});
    commit_value = carry ? NINES : work;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      toggle_q   <= 1'b0;
      pending    <= 1'b0;
      pend_amt   <= 4'd0;
      amt        <= 4'd0;
      carry      <= 1'b0;
      idx        <= '0;
      work       <= '0;
      score      <= '0;
      high_score <= '0;
      new_high   <= 1'b0;
      saturated  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      toggle_q <= score_toggle;
      if (clear) begin
        state     <= IDLE;
        pending   <= 1'b0;
        carry     <= 1'b0;
        idx       <= '0;
        score     <= '0;
        new_high  <= 1'b0;
        saturated <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        // Events arriving mid-addition queue one deep; a second is lost.
        if (state != IDLE && event_hit) begin
          if (!pending) begin
            pending  <= 1'b1;
            pend_amt <= amt_clamped;
          end else begin
            overrun <= 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (pending || event_hit) begin
              work  <= score;
              amt   <= pending ? pend_amt : amt_clamped;
              idx   <= '0;
              carry <= 1'b0;
              state <= ADD;
              // A fresh edge while draining the queued event takes its place.
              pending <= pending && event_hit;
              if (pending && event_hit) pend_amt <= amt_clamped;
            end
          end
          ADD: begin
            work  <= work_next;
            carry <= (digit_sum > 5'd9);
            if (idx == LAST_IDX) state <= CHECK;
            else                 idx   <= idx + 1'b1;
          end
          CHECK: begin
            score <= commit_value;
            if (carry) saturated <= 1'b1;
            // Packed BCD orders the same as its binary reading.
            if (commit_value > high_score) begin
              high_score <= commit_value;
              new_high   <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Bench for score_bcd_accum: decimal-arithmetic reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_score_bcd_accum;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         score_toggle = 1'b0;
  logic [3:0]   add_amount = 4'd0;
  logic [W-1:0] score;
  logic [W-1:0] high_score;
  logic         busy;
  logic         new_high;
  logic         saturated;
  logic         overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  score_bcd_accum #(.DIGITS(DIGITS), .PTR_W(3)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .score_toggle(score_toggle), .add_amount(add_amount),
    .score(score), .high_score(high_score), .busy(busy),
    .new_high(new_high), .saturated(saturated), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // ---------------- reference model (decimal integers, busy countdown) -----
  int m_score = 0, m_high = 0, m_busy = 0, m_job = 0, m_pend_amt = 0;
  bit m_new_high = 0, m_sat = 0, m_over = 0, m_pend = 0, m_tq = 0, m_ev = 0;

  function automatic int clamp_amt(logic [3:0] a);
    return (a > 4'd9) ? 9 : int'(a);
  endfunction

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_score = 0; m_high = 0; m_busy = 0; m_job = 0; m_pend_amt = 0;
      m_new_high = 0; m_sat = 0; m_over = 0; m_pend = 0; m_tq = 0;
    end else begin
      m_ev = score_toggle && !m_tq;
      m_tq = score_toggle;
      if (clear) begin
        m_busy = 0; m_pend = 0; m_score = 0;
        m_new_high = 0; m_sat = 0; m_over = 0;
      end else if (m_busy > 0) begin
        if (m_ev) begin
          if (!m_pend) begin m_pend = 1; m_pend_amt = clamp_amt(add_amount); end
          else m_over = 1;
        end
        m_busy--;
        if (m_busy == 0) begin
          if (m_score + m_job > MAXV) begin m_score = MAXV; m_sat = 1; end
          else m_score = m_score + m_job;
          if (m_score > m_high) begin m_high = m_score; m_new_high = 1; end
        end
      end else if (m_pend || m_ev) begin
        m_job  = m_pend ? m_pend_amt : clamp_amt(add_amount);
        m_busy = DIGITS + 1;
        if (m_pend && m_ev) m_pend_amt = clamp_amt(add_amount);
        else m_pend = 0;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    check("model_score", score, to_bcd(m_score));
    check("model_high", high_score, to_bcd(m_high));
    check("model_busy", W'(busy), W'(m_busy > 0));
    check("model_new_high", W'(new_high), W'(m_new_high));
    check("model_saturated", W'(saturated), W'(m_sat));
    check("model_overrun", W'(overrun), W'(m_over));
  end

  // ---------------- driver tasks -------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_event(input logic [3:0] amt);
    score_toggle = 1'b1;
    add_amount   = amt;
    tick();
    score_toggle = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int idle_cnt;
    bit ok;
    idle_cnt = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (!busy) idle_cnt++; else idle_cnt = 0;
      if (idle_cnt >= 2) ok = 1; else tick();
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic add_and_wait(input logic [3:0] amt);
    send_event(amt);
    wait_idle();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- directed scenarios -------------------------------------
  initial begin
    int cnt;
    do_reset();
    check("reset_score", score, 16'h0000);
    check("reset_high", high_score, 16'h0000);
    check("reset_flags", W'({busy, new_high, saturated, overrun}), W'(0));

    // Single event of 5: busy for DIGITS+1 cycles, result at edge+6.
    score_toggle = 1'b1; add_amount = 4'd5;
    tick();
    score_toggle = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) cnt++;
      if (i == 4) check("t1_score_before", score, 16'h0000);
      if (i == 5) check("t1_score_at_edge6", score, 16'h0005);
      tick();
    end
    check("t1_busy_cycles", W'(cnt), W'(5));
    check("t1_score", score, 16'h0005);
    check("t1_high", high_score, 16'h0005);
    check("t1_new_high", W'(new_high), W'(1));

    // Carry ripple 0099 + 7.
    pulse_clear();
    for (int i = 0; i < 11; i++) add_and_wait(4'd9);
    check("t2_score_99", score, 16'h0099);
    add_and_wait(4'd7);
    check("t2_score", score, 16'h0106);
    check("t2_high", high_score, 16'h0106);

    // Three edges two cycles apart: one queued, one dropped.
    do_reset();
    send_event(4'd1);
    send_event(4'd2);
    send_event(4'd3);
    wait_idle();
    check("t3_score", score, 16'h0003);
    check("t3_overrun", W'(overrun), W'(1));

    // Clear keeps the high score.
    pulse_clear();
    check("t4_clr_score", score, 16'h0000);
    check("t4_clr_flags", W'({new_high, saturated, overrun}), W'(0));
    check("t4_clr_high", high_score, 16'h0003);
    for (int i = 0; i < 4; i++) add_and_wait(4'd9);
    add_and_wait(4'd6);
    check("t4_score_42", score, 16'h0042);
    check("t4_high_42", high_score, 16'h0042);
    pulse_clear();
    check("t4_score_cleared", score, 16'h0000);
    check("t4_high_kept", high_score, 16'h0042);
    check("t4_new_high_cleared", W'(new_high), W'(0));
    add_and_wait(4'd8);
    check("t4_score_8", score, 16'h0008);
    check("t4_high_still_42", high_score, 16'h0042);
    check("t4_new_high_0", W'(new_high), W'(0));

    // Clear during the second ADD cycle aborts the addition.
    score_toggle = 1'b1; add_amount = 4'd4;
    tick();
    score_toggle = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_abort_busy", W'(busy), W'(0));
    repeat (8) tick();
    check("t5_abort_score", score, 16'h0000);
    check("t5_abort_high", high_score, 16'h0042);

    // Amount clamp and zero amount.
    add_and_wait(4'd12);
    check("t6_clamp12", score, 16'h0009);
    score_toggle = 1'b1; add_amount = 4'd0;
    tick();
    score_toggle = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) cnt++;
      tick();
    end
    check("t6_zero_busy_cycles", W'(cnt), W'(5));
    check("t6_zero_score", score, 16'h0009);

    // Edge landing in the CHECK cycle becomes pending, not dropped.
    score_toggle = 1'b1; add_amount = 4'd1;
    tick();
    score_toggle = 1'b0;
    repeat (4) tick();
    score_toggle = 1'b1; add_amount = 4'd2;
    tick();
    score_toggle = 1'b0;
    wait_idle();
    check("t7_check_pending", score, 16'h0012);
    check("t7_no_overrun", W'(overrun), W'(0));

    // Async reset in the middle of ADD.
    score_toggle = 1'b1; add_amount = 4'd3;
    tick();
    score_toggle = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("t8_async_score", score, 16'h0000);
    check("t8_async_high", high_score, 16'h0000);
    check("t8_async_flags", W'({busy, new_high, saturated, overrun}), W'(0));
    tick();
    reset = 1'b0;
    tick();

    // Saturation: 1110 x 9 + 5 = 9995, then +9 clamps, +3 stays.
    for (int i = 0; i < 1110; i++) add_and_wait(4'd9);
    add_and_wait(4'd5);
    check("t9_score_9995", score, 16'h9995);
    add_and_wait(4'd9);
    check("t9_sat_score", score, 16'h9999);
    check("t9_sat_flag", W'(saturated), W'(1));
    check("t9_sat_high", high_score, 16'h9999);
    add_and_wait(4'd3);
    check("t9_sat_hold", score, 16'h9999);
    check("t9_sat_flag_hold", W'(saturated), W'(1));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/score_bcd_accum.md
Name: score_bcd_accum

Overview:
- Parametrised multi-digit BCD score accumulator for the asteroid game; successor to the two-digit toggle-clocked score counter.
- Runs on the system clock and edge-detects score_toggle internally.
- Adds a per-event point value (0-9) digit-serially, saturates at all-9s, and tracks a high score that survives game restarts.
- Outputs feed the seven-segment / on-screen score display.

Parameters:
DIGITS, 4, number of BCD digits in score and high score (min 2).
PTR_W, 3, width of the internal digit index; must satisfy 2^PTR_W >= DIGITS.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state, including the high score
clear  input  1  synchronous game restart; clears score, retains the high score
score_toggle  input  1  level from game logic; each 0->1 transition is one scoring event
add_amount  input  4  points for the event, BCD 0-9; sampled on the event cycle
score  output  4*DIGITS  current score, digit 0 = bits [3:0] = ones
high_score  output  4*DIGITS  highest committed score since reset
busy  output  1  addition in progress
new_high  output  1  sticky; set when high_score is updated during the current game
saturated  output  1  sticky; set when score has clamped to all-9s
overrun  output  1  sticky; set when an event is dropped

Behaviour:
- Reset values: every output 0; state IDLE; toggle_q=0; pending=0.
- Edge detect: event = score_toggle & ~toggle_q, where toggle_q is score_toggle registered every cycle.
- Amount clamp: add_amount values 10-15 are treated as 9. An amount of 0 runs the full sequence with no score change.
- FSM states: IDLE, ADD, CHECK.
- IDLE:
  - On an event, or when pending=1: load work<=score and amt<=clamped amount (the pending amount if pending), set idx<=0 and carry<=0, clear pending, go to ADD.
- ADD, one digit per cycle:
  - s = work[idx] + (idx==0 ? amt : 0) + carry.
  - If s>9: work[idx]<=s-10 and carry<=1; else work[idx]<=s and carry<=0.
  - If idx==DIGITS-1, go to CHECK; else idx<=idx+1.
- CHECK:
  - If carry==1 after the final digit: score<=all 9s and saturated<=1. Otherwise score<=work.
  - Compare the committed value (unsigned BCD magnitude) against high_score. If strictly greater: high_score<=value and new_high<=1.
  - Go to IDLE.
- Latency: event seen in cycle T. busy=1 in cycles T+1..T+DIGITS+1. The new score is visible from T+DIGITS+2, so DIGITS+2 cycles edge-to-result.
- busy = (state != IDLE).
- Events while busy:
  - If pending=0: set pending=1 and store the clamped amount.
  - If pending=1: drop the event and set overrun=1.
  - A pending event starts in the IDLE cycle after CHECK, adding one cycle of gap.
- Saturation: once score is all-9s, further events keep it all-9s and saturated stays 1. high_score may reach all-9s.
- clear, highest priority after reset:
  - Next state is IDLE with pending=0.
  - score, new_high, saturated and overrun are cleared to 0.
  - high_score is unchanged.
  - Any in-progress addition is aborted and not committed.
  - An event coinciding with clear is discarded.
  - toggle_q still updates, so a level held high across clear does not re-trigger.
- reset asserted mid-addition: immediate return to reset values. high_score is lost.
- An event in the same cycle CHECK completes is captured as pending, not dropped.

Test Plan:
- Reset, then one toggle with add_amount=5 -> busy high for 5 cycles; score=0x0005 at edge+6; high_score=0x0005; new_high=1.
- score=0x0099, add_amount=7 -> carries ripple into the hundreds digit; score=0x0106; high_score=0x0106.
- score=0x9995, add_amount=9 -> score=0x9999; saturated=1; a second event of 3 leaves score=0x9999.
- Three edges 2 cycles apart with amounts 1, 2, 3 while busy -> first and second are applied (score=0x0003); third is dropped; overrun=1.
- Reach score=0x0042, pulse clear -> score=0x0000 and flags 0; high_score=0x0042. Next event of 8 -> score=0x0008, high_score stays 0x0042, new_high=0.
- Assert clear in the 2nd ADD cycle -> addition aborted; score=0x0000. Then assert async reset mid-ADD -> all outputs including high_score read 0 before the next clock edge.
- add_amount=12 -> treated as 9. add_amount=0 -> score unchanged; busy still asserts for 5 cycles.
